// File: rtl/serial_arith_pkg.sv
// Shared types and helpers for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    // Sequencer states: waiting for an operand, shifting, holding a result.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Most-negative two's-complement pattern (1 followed by zeros) for widths up to 64.
    function automatic logic [63:0] most_neg_pattern(input int w);
        return 64'd1 << (w - 1);
    endfunction

    // Width of a counter that indexes w shift cycles; never narrower than 1 bit.
    function automatic int cnt_width(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_negate_dp.sv
// Bit-serial two's-complement negation datapath: ~x + 1 evaluated LSB first.
// The carry starts at 1 on every load; each bit is ~x[i] ^ carry and the carry
// survives only while the inverted operand bits stay 1.
module serial_negate_dp
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             reset_b,
    input  logic             load,
    input  logic             shift,
    input  logic             capture,
    input  logic [WIDTH-1:0] load_data,
    output logic             ser_bit,
    output logic [WIDTH-1:0] result_word
);

    logic [WIDTH-1:0] sr;
    logic             carry;
    logic [WIDTH-1:0] result;
    logic             carry_nx;

    // Serial result bit and next carry from the current LSB of the operand.
    always_comb begin
        ser_bit  = ~sr[0] ^ carry;
        carry_nx = ~sr[0] & carry;
    end

    // Operand shift register, carry flop and result collector.
    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            sr     <= '0;
            carry  <= 1'b1;
            result <= '0;
        end else if (load) begin
            sr    <= load_data;
            carry <= 1'b1;
        end else if (shift) begin
            sr     <= {1'b0, sr[WIDTH-1:1]};
            carry  <= carry_nx;
            result <= {ser_bit, result[WIDTH-1:1]};
        end
    end

    // Completed word is latched on the last shift so it stays put while the next operand runs.
    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            result_word <= '0;
        end else if (capture) begin
            result_word <= {ser_bit, result[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/serial_twos_comp_ctrl.sv
// Sequencer for the bit-serial negate: accepts an operand, runs WIDTH shift
// cycles, then presents the negated word until the consumer takes it.
//
// Handshakes: a transfer happens on a rising Clock edge where valid && ready
// are both high. out_valid/out_data/out_ovf stay stable while out_valid is high
// and out_ready is low. In DONE, in_ready follows out_ready combinationally so
// a new operand can be loaded on the same edge the result is taken.
module serial_twos_comp_ctrl
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clock,
    input  logic             reset_b,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy,
    output logic             ser_bit,
    output logic             ser_valid,
    output state_t           dbg_state
);

    localparam int               CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]    LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_neg_pattern(WIDTH));

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic          rdy;
    logic          load;
    logic          shift;
    logic          capture;
    logic          last_cnt;
    logic          ovf_pend;
    logic          ovf_q;
    logic          dp_bit;

    // Next-state and control strobes.
    always_comb begin
        state_nx = state;
        rdy      = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        last_cnt = (cnt == LAST);
        case (state)
            IDLE: begin
                rdy = 1'b1;
                if (in_valid) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                shift = 1'b1;
                if (last_cnt) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                rdy = out_ready;
                if (out_ready) begin
                    if (in_valid) begin
                        load     = 1'b1;
                        state_nx = SHIFT;
                    end else begin
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
        capture = shift && last_cnt;
    end

    // State register.
    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Shift-cycle counter, restarted on every load.
    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (shift) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Overflow flag: noted at load, published alongside the result word.
    always_ff @(posedge Clock or negedge reset_b) begin
        if (!reset_b) begin
            ovf_pend <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (load) begin
                ovf_pend <= (in_data == MOST_NEG);
            end
            if (capture) begin
                ovf_q <= ovf_pend;
            end
        end
    end

    serial_negate_dp #(
        .WIDTH(WIDTH)
    ) u_dp (
        .Clock      (Clock),
        .reset_b    (reset_b),
        .load       (load),
        .shift      (shift),
        .capture    (capture),
        .load_data  (in_data),
        .ser_bit    (dp_bit),
        .result_word(out_data)
    );

    // Output decode; in_ready is forced low while reset is asserted.
    always_comb begin
        in_ready  = rdy & reset_b;
        out_valid = (state == DONE);
        busy      = (state == SHIFT) || (state == DONE);
        ser_valid = (state == SHIFT);
        ser_bit   = dp_bit & ser_valid;
        out_ovf   = ovf_q;
        dbg_state = state;
    end

endmodule

// File: tb/tb_serial_twos_comp_ctrl.sv
// Directed bench for serial_twos_comp_ctrl with WIDTH = 8.
module tb_serial_twos_comp_ctrl;
    import serial_arith_pkg::*;

    localparam int W = 8;

    logic         Clock = 1'b0;
    logic         reset_b = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         busy;
    logic         ser_bit;
    logic         ser_valid;
    state_t       dbg_state;

    int n_vec = 0;
    int n_err = 0;

    serial_twos_comp_ctrl #(.WIDTH(W)) dut (
        .Clock    (Clock),
        .reset_b  (reset_b),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_ovf  (out_ovf),
        .busy     (busy),
        .ser_bit  (ser_bit),
        .ser_valid(ser_valid),
        .dbg_state(dbg_state)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs are changed and outputs sampled 1 time unit after it.
    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Offer one operand from IDLE with out_ready high and check the full operation.
    task automatic run_op(input string tag, input logic [W-1:0] d,
                          input logic [W-1:0] exp, input logic exp_ovf);
        in_data  = d;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, {7'd0, in_ready}, 8'd1);
        step();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) begin
            check({tag, "_ser_bit"}, {7'd0, ser_bit}, {7'd0, exp[i]});
            check({tag, "_busy"}, {7'd0, busy}, 8'd1);
            step();
        end
        check({tag, "_out_valid"}, {7'd0, out_valid}, 8'd1);
        check({tag, "_out_data"}, out_data, exp);
        check({tag, "_out_ovf"}, {7'd0, out_ovf}, {7'd0, exp_ovf});
        step();
        check({tag, "_idle"}, {6'd0, dbg_state}, {6'd0, IDLE});
        check({tag, "_hold"}, out_data, exp);
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_in_ready", {7'd0, in_ready}, 8'd0);
        check("rst_out_valid", {7'd0, out_valid}, 8'd0);
        check("rst_busy", {7'd0, busy}, 8'd0);
        check("rst_ser_valid", {7'd0, ser_valid}, 8'd0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_out_ovf", {7'd0, out_ovf}, 8'd0);
        step();
        reset_b = 1'b1;
        #1;
        check("post_rst_in_ready", {7'd0, in_ready}, 8'd1);
        out_ready = 1'b1;

        // Basic: 0x05 -> 0xFB, ser bits 1,1,0,1,1,1,1,1.
        run_op("basic", 8'h05, 8'hFB, 1'b0);

        // Zero and most-negative.
        run_op("zero", 8'h00, 8'h00, 1'b0);
        run_op("mneg", 8'h80, 8'h80, 1'b1);

        // Back-to-back: 0x01 then 0xFF with in_valid and out_ready held high.
        in_data  = 8'h01;
        in_valid = 1'b1;
        step();
        in_data = 8'hFF;
        for (int i = 0; i < W; i++) begin
            check("b2b_shift_in_ready", {7'd0, in_ready}, 8'd0);
            step();
        end
        check("b2b_first_valid", {7'd0, out_valid}, 8'd1);
        check("b2b_first_data", out_data, 8'hFF);
        check("b2b_in_ready_done", {7'd0, in_ready}, 8'd1);
        step();
        in_valid = 1'b0;
        check("b2b_no_idle_gap", {6'd0, dbg_state}, {6'd0, SHIFT});
        check("b2b_gap_out_valid", {7'd0, out_valid}, 8'd0);
        for (int i = 0; i < W - 1; i++) begin
            step();
            check("b2b_second_wait", {7'd0, out_valid}, 8'd0);
        end
        step();
        check("b2b_second_valid", {7'd0, out_valid}, 8'd1);
        check("b2b_second_data", out_data, 8'h01);
        step();
        check("b2b_end_idle", {6'd0, dbg_state}, {6'd0, IDLE});

        // Backpressure: 0x7F -> 0x81 held for 5 cycles with out_ready low.
        out_ready = 1'b0;
        in_data   = 8'h7F;
        in_valid  = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < W; i++) step();
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", {7'd0, out_valid}, 8'd1);
            check("bp_out_data", out_data, 8'h81);
            check("bp_in_ready", {7'd0, in_ready}, 8'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", {7'd0, in_ready}, 8'd1);
        check("bp_release_data", out_data, 8'h81);
        step();
        check("bp_end_out_valid", {7'd0, out_valid}, 8'd0);
        check("bp_end_busy", {7'd0, busy}, 8'd0);

        // Reset mid-SHIFT after 3 shift cycles of 0x33.
        in_data  = 8'h33;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("mid_busy_before", {7'd0, busy}, 8'd1);
        reset_b = 1'b0;
        #1;
        check("mid_rst_busy", {7'd0, busy}, 8'd0);
        check("mid_rst_ser_valid", {7'd0, ser_valid}, 8'd0);
        check("mid_rst_in_ready", {7'd0, in_ready}, 8'd0);
        check("mid_rst_out_data", out_data, 8'h00);
        check("mid_rst_out_valid", {7'd0, out_valid}, 8'd0);
        step();
        step();
        reset_b = 1'b1;
        #1;
        for (int i = 0; i < 12; i++) begin
            check("mid_no_out_valid", {7'd0, out_valid}, 8'd0);
            step();
        end
        run_op("post_rst", 8'h7F, 8'h81, 1'b0);

        // Input activity during SHIFT must be ignored: 0x12 -> 0xEE.
        in_data  = 8'h12;
        in_valid = 1'b1;
        step();
        for (int i = 0; i < W; i++) begin
            in_valid = i[0];
            in_data  = 8'hA5 ^ 8'(i * 37);
            #1;
            check("ign_in_ready", {7'd0, in_ready}, 8'd0);
            step();
        end
        in_valid = 1'b0;
        check("ign_out_valid", {7'd0, out_valid}, 8'd1);
        check("ign_out_data", out_data, 8'hEE);
        check("ign_out_ovf", {7'd0, out_ovf}, 8'd0);
        step();
        check("ign_end_idle", {6'd0, dbg_state}, {6'd0, IDLE});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
